// File: rtl/cp0_exc.sv
// cp0_exc -- coprocessor-0 exception/interrupt responder.
//
// Sits beside the M stage. Holds SR (12), Cause (13), EPC (14) and the
// constant PRId (15), serves mfc0 reads and mtc0 writes, and raises IntReq
// when a hardware interrupt or an M-stage exception must be taken at the
// M/W boundary.
//
// Ports:
//   clk     in   1  rising-edge clock
//   reset   in   1  asynchronous, active-high reset
//   A1      in   5  mfc0 read register number
//   A2      in   5  mtc0 write register number
//   DIn     in  32  mtc0 write data
//   We      in   1  mtc0 write enable
//   EXLClr  in   1  eret in M: clears SR.EXL
//   PCM     in  32  PC of the instruction in M
//   causeM  in  32  cause word of the M instruction (BD=[31], ExcCode=[6:2])
//   HWInt   in   6  level-sensitive hardware interrupt lines
//   IntReq  out  1  take the exception this cycle (combinational)
//   EPC     out 32  current EPC, the eret target
//   DOut    out 32  combinational read data for A1
module cp0_exc #(
  parameter logic [31:0] PRID = 32'h0000_8888
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic        EXLClr,
  input  logic [31:0] PCM,
  input  logic [31:0] causeM,
  input  logic [5:0]  HWInt,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [4:0] RegSr    = 5'd12;
  localparam logic [4:0] RegCause = 5'd13;
  localparam logic [4:0] RegEpc   = 5'd14;
  localparam logic [4:0] RegPrid  = 5'd15;

  logic [5:0]  srIm;
  logic        srExl;
  logic        srIe;
  logic        causeBd;
  logic [5:0]  causeIp;
  logic [4:0]  causeExc;
  logic [31:0] epcReg;

  logic        irq;
  logic        exc;
  logic [31:0] excPc;
  logic [31:0] srWord;
  logic [31:0] causeWord;
  logic        unusedCauseBits;

  // Cause bits outside BD and ExcCode carry no information.
  assign unusedCauseBits = ^{causeM[30:7], causeM[1:0]};

  // Interrupts outrank the synchronous exception; EXL masks both.
  assign irq    = (|(HWInt & srIm)) & srIe & ~srExl;
  assign exc    = (causeM[6:2] != 5'd0) & ~srExl;
  assign IntReq = irq | exc;

  // A faulting delay-slot instruction restarts at its branch; wraps mod 2^32.
  assign excPc = causeM[31] ? (PCM - 32'd4) : PCM;

  assign srWord    = {16'd0, srIm, 8'd0, srExl, srIe};
  assign causeWord = {causeBd, 15'd0, causeIp, 3'd0, causeExc, 2'd0};
  assign EPC       = epcReg;

  always_comb begin
    DOut = 32'd0;
    case (A1)
      RegSr:    DOut = srWord;
      RegCause: DOut = causeWord;
      RegEpc:   DOut = epcReg;
      RegPrid:  DOut = PRID;
      default:  DOut = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srIm     <= 6'd0;
      srExl    <= 1'b0;
      srIe     <= 1'b0;
      causeBd  <= 1'b0;
      causeIp  <= 6'd0;
      causeExc <= 5'd0;
      epcReg   <= 32'd0;
    end else begin
      causeIp <= HWInt;
      if (IntReq) begin
        // Taking the exception wins over any mtc0 or eret in the same cycle.
        srExl    <= 1'b1;
        causeBd  <= causeM[31];
        causeExc <= irq ? 5'd0 : causeM[6:2];
        epcReg   <= {excPc[31:2], 2'b00};
      end else begin
        if (We && (A2 == RegSr)) begin
          srIm  <= DIn[15:10];
          srExl <= DIn[1];
          srIe  <= DIn[0];
        end
        if (We && (A2 == RegEpc)) begin
          epcReg <= {DIn[31:2], 2'b00};
        end
        // Placed after the SR write so eret's clear of EXL has the last word.
        if (EXLClr) begin
          srExl <= 1'b0;
        end
      end
    end
  end

endmodule
